// File: rtl/ll_wr_arb.sv
// ll_wr_arb: round-robin arbiter sharing the linked-list write controller.
// One write in flight; the allocated pointer is returned on completion.
module ll_wr_arb #(
  parameter int NUM_REQ    = 2,
  parameter int WR_DATA_WD = 32,
  parameter int PTR_WD     = 8,
  parameter int BUSY_TMO   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*WR_DATA_WD-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_insert,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          cmpl_vld,
  output logic [$clog2(NUM_REQ)-1:0]    cmpl_id,
  output logic [PTR_WD-1:0]             cmpl_ptr,
  output logic                          cmpl_err,
  output logic                          tmo_err,
  input  logic                          free_ptr_avail,
  output logic [WR_DATA_WD-1:0]         data_to_wr,
  output logic                          data_to_wr_req,
  output logic                          insert_data,
  input  logic                          wr_ctrl_fsm_ready,
  input  logic                          upd_nxt_ptr,
  input  logic [PTR_WD-1:0]             cur_nxt_ptr
);

  localparam int ID_WD  = $clog2(NUM_REQ);
  localparam int CNT_WD = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ID_WD-1:0]      rr_ptr;
  logic [ID_WD-1:0]      rr_nxt;
  logic [ID_WD-1:0]      win_id;
  logic                  win_vld;
  logic [WR_DATA_WD-1:0] win_data;
  logic                  win_ins;
  logic [ID_WD-1:0]      lat_id;
  logic [WR_DATA_WD-1:0] lat_data;
  logic                  lat_ins;
  logic [PTR_WD-1:0]     cap_ptr;
  logic [CNT_WD-1:0]     tmo_cnt;

  logic                  grant;
  logic                  tmo_hit;
  logic                  done_hit;
  logic [NUM_REQ-1:0]    req_ack_d;
  logic                  cmpl_vld_d;
  logic [ID_WD-1:0]      cmpl_id_d;
  logic [PTR_WD-1:0]     cmpl_ptr_d;
  logic                  cmpl_err_d;

  // Two passes: indices at/after rr_ptr first, then the wrapped ones.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_data = '0;
    win_ins  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req_vld[i] && ID_WD'(i) >= rr_ptr) begin
        win_vld = 1'b1;
        win_id  = ID_WD'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req_vld[i]) begin
        win_vld = 1'b1;
        win_id  = ID_WD'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_WD'(i)) begin
        win_data = req_data[i*WR_DATA_WD +: WR_DATA_WD];
        win_ins  = req_insert[i];
      end
    end
  end

  assign rr_nxt = (win_id == ID_WD'(NUM_REQ - 1)) ?
                  '0 : win_id + 1'b1;

  assign grant = (state == IDLE) && win_vld &&
                 wr_ctrl_fsm_ready && free_ptr_avail;

  assign tmo_hit = (state == WAIT_BUSY) && wr_ctrl_fsm_ready &&
                   (tmo_cnt == CNT_WD'(BUSY_TMO - 1));

  assign done_hit = (state == WAIT_DONE) && wr_ctrl_fsm_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (grant) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!wr_ctrl_fsm_ready) state_nxt = WAIT_DONE;
        else if (tmo_hit)       state_nxt = IDLE;
      end
      WAIT_DONE: if (done_hit) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ack_d = '0;
    if (grant) req_ack_d[win_id] = 1'b1;
    cmpl_vld_d = tmo_hit | done_hit;
    cmpl_id_d  = cmpl_id;
    cmpl_ptr_d = cmpl_ptr;
    cmpl_err_d = cmpl_err;
    unique case (1'b1)
      tmo_hit: begin
        cmpl_id_d  = lat_id;
        cmpl_ptr_d = '0;
        cmpl_err_d = 1'b1;
      end
      done_hit: begin
        cmpl_id_d  = lat_id;
        cmpl_ptr_d = upd_nxt_ptr ? cur_nxt_ptr : cap_ptr;
        cmpl_err_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_ack        <= '0;
      cmpl_vld       <= 1'b0;
      cmpl_id        <= '0;
      cmpl_ptr       <= '0;
      cmpl_err       <= 1'b0;
      tmo_err        <= 1'b0;
      data_to_wr     <= '0;
      data_to_wr_req <= 1'b0;
      insert_data    <= 1'b0;
      rr_ptr         <= '0;
      lat_id         <= '0;
      lat_data       <= '0;
      lat_ins        <= 1'b0;
      cap_ptr        <= '0;
      tmo_cnt        <= '0;
    end else begin
      req_ack        <= req_ack_d;
      cmpl_vld       <= cmpl_vld_d;
      cmpl_id        <= cmpl_id_d;
      cmpl_ptr       <= cmpl_ptr_d;
      cmpl_err       <= cmpl_err_d;
      data_to_wr_req <= (state == ISSUE);
      data_to_wr     <= (state == ISSUE) ? lat_data : '0;
      insert_data    <= (state == ISSUE) && lat_ins;
      if (tmo_hit) tmo_err <= 1'b1;
      if (grant) begin
        rr_ptr   <= rr_nxt;
        lat_id   <= win_id;
        lat_data <= win_data;
        lat_ins  <= win_ins;
        cap_ptr  <= '0;
      end else if (upd_nxt_ptr &&
                   (state == WAIT_BUSY || state == WAIT_DONE)) begin
        cap_ptr <= cur_nxt_ptr;
      end
      if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
      else                    tmo_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ll_wr_arb.sv
// tb_ll_wr_arb: scoreboard bench for ll_wr_arb with a write-controller model.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_ll_wr_arb;

  localparam int TMO = 16;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] data;
    logic        ins;
  } ack_t;

  typedef struct {
    logic       id;
    logic [7:0] ptr;
    logic       err;
  } cmpl_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_vld = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_insert = '0;
  logic [1:0]  req_ack;
  logic        cmpl_vld;
  logic [0:0]  cmpl_id;
  logic [7:0]  cmpl_ptr;
  logic        cmpl_err;
  logic        tmo_err;
  logic        free_ptr_avail = 1'b1;
  logic [31:0] data_to_wr;
  logic        data_to_wr_req;
  logic        insert_data;
  logic        wr_ctrl_fsm_ready = 1'b1;
  logic        upd_nxt_ptr = 1'b0;
  logic [7:0]  cur_nxt_ptr = '0;

  ack_t  ack_q[$];
  ack_t  issue_q[$];
  cmpl_t cmpl_q[$];
  logic [7:0] ptr_q[$];

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  cmpl_cnt = 0;
  int  req_cyc = 0;
  int  cmpl_cyc = 0;
  bit  tmo_mode = 1'b0;

  ll_wr_arb #(
    .NUM_REQ(2), .WR_DATA_WD(32), .PTR_WD(8), .BUSY_TMO(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_vld(req_vld),
    .req_data(req_data),
    .req_insert(req_insert),
    .req_ack(req_ack),
    .cmpl_vld(cmpl_vld),
    .cmpl_id(cmpl_id),
    .cmpl_ptr(cmpl_ptr),
    .cmpl_err(cmpl_err),
    .tmo_err(tmo_err),
    .free_ptr_avail(free_ptr_avail),
    .data_to_wr(data_to_wr),
    .data_to_wr_req(data_to_wr_req),
    .insert_data(insert_data),
    .wr_ctrl_fsm_ready(wr_ctrl_fsm_ready),
    .upd_nxt_ptr(upd_nxt_ptr),
    .cur_nxt_ptr(cur_nxt_ptr)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_op(input int id, input logic [31:0] d,
                         input logic ins, input logic [7:0] ptr,
                         input logic err);
    ack_t  a;
    cmpl_t c;
    a.ack  = 2'b01 << id;
    a.data = d;
    a.ins  = ins;
    ack_q.push_back(a);
    if (!err) ptr_q.push_back(ptr);
    c.id  = id[0];
    c.ptr = err ? 8'h00 : ptr;
    c.err = err;
    cmpl_q.push_back(c);
    req_data[id*32 +: 32] = d;
    req_insert[id] = ins;
  endtask

  task automatic wait_ack(output int lat);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (req_ack == 2'b00 && i < 100);
    lat = i;
    chk("ack_seen", req_ack != 2'b00, 1);
  endtask

  task automatic wait_cmpl(input int tgt, input string name);
    for (int i = 0; i < 300 && cmpl_cnt < tgt; i++) @(negedge clk);
    chk(name, cmpl_cnt, tgt);
  endtask

  // Write-controller model: busy shortly after a request, allocates a pointer.
  initial forever begin
    @(negedge clk);
    if (reset_n && data_to_wr_req && !tmo_mode) begin
      @(negedge clk);
      wr_ctrl_fsm_ready = 1'b0;
      @(negedge clk);
      upd_nxt_ptr = 1'b1;
      cur_nxt_ptr = (ptr_q.size() > 0) ? ptr_q.pop_front() : 8'hEE;
      @(negedge clk);
      upd_nxt_ptr = 1'b0;
      repeat (2) @(negedge clk);
      wr_ctrl_fsm_ready = 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    ack_t  a;
    cmpl_t c;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (req_ack != 2'b00) begin
          if (ack_q.size() == 0) chk("ack_unexpected", req_ack, 0);
          else begin
            a = ack_q.pop_front();
            chk("ack_onehot", req_ack, a.ack);
            issue_q.push_back(a);
          end
        end
        if (data_to_wr_req) begin
          req_cyc = cyc;
          if (issue_q.size() == 0) chk("req_unexpected", 1, 0);
          else begin
            a = issue_q.pop_front();
            chk("wr_data", data_to_wr, a.data);
            chk("wr_insert", insert_data, a.ins);
          end
        end else begin
          chk("wr_idle", {data_to_wr, insert_data}, 0);
        end
        if (cmpl_vld) begin
          cmpl_cyc = cyc;
          cmpl_cnt++;
          if (cmpl_q.size() == 0) chk("cmpl_unexpected", 1, 0);
          else begin
            c = cmpl_q.pop_front();
            chk("cmpl_id", cmpl_id, c.id);
            chk("cmpl_ptr", cmpl_ptr, c.ptr);
            chk("cmpl_err", cmpl_err, c.err);
          end
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_ack"}, req_ack, 0);
    chk({tag, "_cvld"}, cmpl_vld, 0);
    chk({tag, "_cid"}, cmpl_id, 0);
    chk({tag, "_cptr"}, cmpl_ptr, 0);
    chk({tag, "_cerr"}, cmpl_err, 0);
    chk({tag, "_tmo"}, tmo_err, 0);
    chk({tag, "_wdata"}, data_to_wr, 0);
    chk({tag, "_wreq"}, data_to_wr_req, 0);
    chk({tag, "_wins"}, insert_data, 0);
  endtask

  initial begin
    int   lat;
    int   base;
    int   n;
    int   i;
    ack_t a;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset("rst");

    // Single request
    push_op(0, 32'hA5A5_0001, 1'b0, 8'h07, 1'b0);
    req_vld = 2'b01;
    wait_ack(lat);
    chk("t1_ack_lat", lat, 1);
    chk("t1_ack", req_ack, 2'b01);
    req_vld = 2'b00;
    @(negedge clk);
    chk("t1_req", data_to_wr_req, 1);
    chk("t1_data", data_to_wr, 32'hA5A5_0001);
    wait_cmpl(1, "t1_cmpl");
    chk("t1_ptr_hold", cmpl_ptr, 8'h07);

    // Contention from a fresh rr_ptr: order 0,1,0
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push_op(0, 32'h1111_0000, 1'b0, 8'h11, 1'b0);
    push_op(1, 32'h2222_0000, 1'b1, 8'h22, 1'b0);
    push_op(0, 32'h1111_0000, 1'b0, 8'h33, 1'b0);
    req_vld = 2'b11;
    n = 0;
    for (int k = 0; k < 300 && n < 3; k++) begin
      @(negedge clk);
      if (req_ack != 2'b00) n++;
    end
    req_vld = 2'b00;
    chk("t2_acks", n, 3);
    wait_cmpl(4, "t2_cmpl");

    // Backpressure on free pointers
    free_ptr_avail = 1'b0;
    req_data[32 +: 32] = 32'h3333_0003;
    req_insert[1] = 1'b0;
    req_vld = 2'b10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_no_ack", req_ack, 0);
      chk("t3_no_req", data_to_wr_req, 0);
    end
    push_op(1, 32'h3333_0003, 1'b0, 8'h44, 1'b0);
    free_ptr_avail = 1'b1;
    @(negedge clk);
    chk("t3_ack", req_ack, 2'b10);
    req_vld = 2'b00;
    wait_cmpl(5, "t3_cmpl");

    // Timeout: controller never goes busy
    tmo_mode = 1'b1;
    push_op(0, 32'h4444_0004, 1'b1, 8'h00, 1'b1);
    req_vld = 2'b01;
    wait_ack(lat);
    req_vld = 2'b00;
    wait_cmpl(6, "t4_cmpl");
    chk("t4_lat", cmpl_cyc - req_cyc, TMO);
    chk("t4_tmo", tmo_err, 1);
    repeat (5) @(negedge clk);
    chk("t4_tmo_sticky", tmo_err, 1);
    chk("t4_err_hold", cmpl_err, 1);
    tmo_mode = 1'b0;

    // Reset while waiting for the write to finish
    a.ack  = 2'b10;
    a.data = 32'h5555_0005;
    a.ins  = 1'b0;
    ack_q.push_back(a);
    ptr_q.push_back(8'h55);
    req_data[32 +: 32] = 32'h5555_0005;
    req_insert = 2'b00;
    req_vld = 2'b10;
    wait_ack(lat);
    req_vld = 2'b00;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_reset("t5");
    base = cmpl_cnt;
    repeat (8) @(negedge clk);
    chk("t5_no_cmpl", cmpl_cnt, base);
    push_op(0, 32'h6666_0006, 1'b0, 8'h66, 1'b0);
    req_data[32 +: 32] = 32'h6767_0007;
    req_vld = 2'b11;
    wait_ack(lat);
    chk("t5_ack_id0", req_ack, 2'b01);
    req_vld = 2'b00;
    wait_cmpl(7, "t5_cmpl");

    // Back-to-back re-request in the completion cycle
    push_op(1, 32'h7777_0007, 1'b1, 8'h77, 1'b0);
    req_vld = 2'b10;
    wait_ack(lat);
    req_vld = 2'b00;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!cmpl_vld && i < 300);
    chk("t6_cmpl_seen", cmpl_vld, 1);
    push_op(1, 32'h8888_0008, 1'b1, 8'h88, 1'b0);
    req_vld = 2'b10;
    @(negedge clk);
    chk("t6_ack_b2b", req_ack, 2'b10);
    req_vld = 2'b00;
    @(negedge clk);
    chk("t6_ins", insert_data, 1);
    wait_cmpl(9, "t6_cmpl");

    repeat (5) @(negedge clk);
    chk("end_ack_q", ack_q.size(), 0);
    chk("end_issue_q", issue_q.size(), 0);
    chk("end_cmpl_q", cmpl_q.size(), 0);
    chk("end_ptr_q", ptr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
